// File: rtl/counter_pkg.sv
// counter_pkg: shared mode encodings for the prescaled up/down counter
//   MODE_WRAP    - boundary tick wraps (up -> 0, down -> modulus)
//   MODE_SAT     - boundary tick holds the count
//   MODE_ONESHOT - counts to the end value once, then sets done
//   2'b11 is not named and behaves as wrap
package counter_pkg;
   localparam logic [1:0] MODE_WRAP    = 2'b00;
   localparam logic [1:0] MODE_SAT     = 2'b01;
   localparam logic [1:0] MODE_ONESHOT = 2'b10;
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: emits one tick every div+1 enabled cycles
//   clock  - rising-edge clock
//   reset  - synchronous active-high reset, prescaler to 0
//   enable - advances the prescaler; low holds it
//   clear  - synchronous restart of the prescaler at 0
//   div    - divide value; tick when prescaler equals div
//   tick   - combinational, high in the cycle the prescaler equals div
module tick_prescaler #(
   parameter int PRESC_W = 8
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               enable,
   input  logic               clear,
   input  logic [PRESC_W-1:0] div,
   output logic               tick
);
   logic [PRESC_W-1:0] r_cnt = '0;
   assign tick = enable && (r_cnt == div);
   always_ff @(posedge clock) begin
      if (reset || clear) r_cnt <= '0;
      else if (enable) r_cnt <= tick ? '0 : r_cnt + PRESC_W'(1);
   end
endmodule

// File: rtl/prescaled_updown_counter.sv
// prescaled_updown_counter: prescaled up/down counter with wrap, saturate and one-shot modes
//   clock, reset     - rising-edge clock, synchronous active-high reset
//   enable           - advances the prescaler and permits counting
//   load, load_value - load count (clamped to modulus); beats any tick
//   dir              - 1 up, 0 down
//   mode             - counter_pkg encodings; 2'b11 acts as wrap
//   modulus          - terminal count value
//   presc_div        - step once every presc_div+1 enabled cycles
//   clear_ovf        - clears sticky ovf (a simultaneous set wins)
//   count            - current count
//   tc               - registered one-cycle pulse after a boundary / done-setting tick
//   ovf              - sticky, set on any wrap/saturate boundary tick
//   done             - one-shot finished level
module prescaled_updown_counter
   import counter_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int PRESC_W = 8
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               enable,
   input  logic               load,
   input  logic [WIDTH-1:0]   load_value,
   input  logic               dir,
   input  logic [1:0]         mode,
   input  logic [WIDTH-1:0]   modulus,
   input  logic [PRESC_W-1:0] presc_div,
   input  logic               clear_ovf,
   output logic [WIDTH-1:0]   count,
   output logic               tc,
   output logic               ovf,
   output logic               done
);
   logic [WIDTH-1:0] r_count = '0;
   logic             r_tc    = 1'b0;
   logic             r_ovf   = 1'b0;
   logic             r_done  = 1'b0;
   logic             w_tick;
   logic             w_oneshot;
   logic             w_sat;
   logic             w_bound;
   logic             w_end;
   logic [WIDTH-1:0] w_next;
   logic [WIDTH-1:0] w_wrap_val;
   logic [WIDTH-1:0] w_load_val;

   tick_prescaler #(.PRESC_W(PRESC_W)) u_presc (
      .clock  (clock),
      .reset  (reset),
      .enable (enable),
      .clear  (load),
      .div    (presc_div),
      .tick   (w_tick)
   );

   assign w_oneshot  = mode == MODE_ONESHOT;
   assign w_sat      = mode == MODE_SAT;
   // >= so a count left above a lowered modulus is still treated as the up boundary
   assign w_bound    = dir ? (r_count >= modulus) : (r_count == '0);
   assign w_next     = dir ? r_count + WIDTH'(1) : r_count - WIDTH'(1);
   assign w_end      = dir ? (w_next == modulus) : (w_next == '0);
   assign w_wrap_val = dir ? '0 : modulus;
   assign w_load_val = (load_value > modulus) ? modulus : load_value;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_count <= '0;
         r_tc    <= 1'b0;
         r_ovf   <= 1'b0;
         r_done  <= 1'b0;
      end else if (load) begin
         r_count <= w_load_val;
         r_tc    <= 1'b0;
         r_done  <= 1'b0;
         r_ovf   <= r_ovf & ~clear_ovf;
      end else begin
         r_tc  <= 1'b0;
         r_ovf <= r_ovf & ~clear_ovf;
         if (w_tick && !(w_oneshot && r_done)) begin
            if (w_oneshot) begin
               // already sitting on the end value (e.g. loaded there): finish without moving
               if (!w_bound) r_count <= w_next;
               if (w_bound || w_end) begin
                  r_done <= 1'b1;
                  r_tc   <= 1'b1;
               end
            end else if (w_bound) begin
               if (!w_sat) r_count <= w_wrap_val;
               r_tc  <= 1'b1;
               r_ovf <= 1'b1;
            end else begin
               r_count <= w_next;
            end
         end
      end
   end

   assign count = r_count;
   assign tc    = r_tc;
   assign ovf   = r_ovf;
   assign done  = r_done;
endmodule
